// File: rtl/match_event_logger.sv
// Timestamps each accepted match pulse into a small FWFT FIFO, with a
// saturating hit counter and a sticky overflow flag.
module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       match,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           match_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [LW-1:0]   lvl_nxt;

    logic hit;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign full = (fifo_level == LW'(DEPTH));
    assign hit  = match & enable & ~clear;
    assign pop  = rd_valid & rd_ready & ~clear;
    // A pop frees the slot the write pointer sits on when full.
    assign push = hit & (~full | pop);
    assign drop = hit & full & ~pop;

    assign rd_data = mem[rptr];

    always_comb begin
        lvl_nxt = fifo_level;
        if (clear) begin
            lvl_nxt = '0;
        end else if (push && !pop) begin
            lvl_nxt = fifo_level + LW'(1);
        end else if (pop && !push) begin
            lvl_nxt = fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts          <= '0;
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= '0;
            rd_valid    <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ts         <= ts + TS_W'(1);
            fifo_level <= lvl_nxt;
            rd_valid   <= (lvl_nxt != '0);
            if (clear) begin
                wptr        <= '0;
                rptr        <= '0;
                match_count <= '0;
                overflow    <= 1'b0;
            end else begin
                if (push) begin
                    mem[wptr] <= ts;
                    wptr      <= wptr + AW'(1);
                end
                if (pop) begin
                    rptr <= rptr + AW'(1);
                end
                if (hit && (match_count != '1)) begin
                    match_count <= match_count + CNT_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_match_event_logger.sv
// Bench for match_event_logger: directed scenarios plus randomized traffic
// checked against a queue-based model.
module tb_match_event_logger;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        match;
    logic        enable;
    logic        clear;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  fifo_level;
    logic [15:0] match_count;
    logic        overflow;

    logic        s_rst;
    logic        s_match;
    logic        s_enable;
    logic        s_clear;
    logic        s_rdy;
    logic        s_valid;
    logic [3:0]  s_data;
    logic [3:0]  s_level;
    logic [3:0]  s_count;
    logic        s_ovf;

    int          n_vec = 0;
    int          n_err = 0;

    logic [15:0] q[$];
    int          mcnt;
    bit          movf;
    logic [15:0] mts;

    always #5 clk = ~clk;

    match_event_logger #(.TS_W(16), .CNT_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .match(match), .enable(enable),
        .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .fifo_level(fifo_level),
        .match_count(match_count), .overflow(overflow)
    );

    match_event_logger #(.TS_W(4), .CNT_W(4), .DEPTH(8)) dut_small (
        .clk(clk), .rst(s_rst), .match(s_match), .enable(s_enable),
        .clear(s_clear), .rd_ready(s_rdy), .rd_valid(s_valid),
        .rd_data(s_data), .fifo_level(s_level),
        .match_count(s_count), .overflow(s_ovf)
    );

    // Drive one cycle and advance the reference model on the same edge.
    task automatic step(input logic m, input logic e, input logic c,
                        input logic r);
        logic        hit;
        logic        pop;
        logic [15:0] tmp;
        match    = m;
        enable   = e;
        clear    = c;
        rd_ready = r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mcnt = 0;
            movf = 0;
            mts  = 16'd0;
        end else begin
            hit = m && e && !c;
            pop = (q.size() > 0) && r && !c;
            if (c) begin
                q.delete();
                mcnt = 0;
                movf = 0;
            end else begin
                if (pop) tmp = q.pop_front();
                if (hit) begin
                    if (q.size() < DEPTH) q.push_back(mts);
                    else movf = 1;
                    if (mcnt < 65535) mcnt++;
                end
            end
            mts = mts + 16'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %0b want 0", rd_valid);
        end
        n_vec++;
        if (rd_data !== 16'd0) begin
            n_err++;
            $display("FAIL reset_data: got %0d want 0", rd_data);
        end
        n_vec++;
        if (fifo_level !== 4'd0) begin
            n_err++;
            $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        n_vec++;
        if (match_count !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt_ovf: got %0d/%0b want 0/0",
                     match_count, overflow);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp [2];
        exp = '{16'd6, 16'd9};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step((c == 5) || (c == 6) || (c == 9), 1, 0, 0);
        end
        n_vec++;
        if (fifo_level !== 4'd3 || match_count !== 16'd3) begin
            n_err++;
            $display("FAIL basic_level_cnt: got %0d/%0d want 3/3",
                     fifo_level, match_count);
        end
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 16'd5) begin
            n_err++;
            $display("FAIL basic_head: got %0b/%0d want 1/5",
                     rd_valid, rd_data);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 1);
            n_vec++;
            if (rd_data !== exp[k]) begin
                n_err++;
                $display("FAIL basic_drain%0d: got %0d want %0d",
                         k, rd_data, exp[k]);
            end
        end
        step(0, 1, 0, 1);
        n_vec++;
        if (rd_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_err++;
            $display("FAIL basic_empty: got %0b/%0d want 0/0",
                     rd_valid, fifo_level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(c >= 10, 1, 0, 0);
        end
        n_vec++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 ||
            match_count !== 16'd10) begin
            n_err++;
            $display("FAIL ovf_state: got %0d/%0b/%0d want 8/1/10",
                     fifo_level, overflow, match_count);
        end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (rd_data !== 16'(10 + k)) begin
                n_err++;
                $display("FAIL ovf_drain%0d: got %0d want %0d",
                         k, rd_data, 10 + k);
            end
            step(0, 1, 0, 1);
        end
        n_vec++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: got %0b/%0b want 0/1",
                     rd_valid, overflow);
        end
        step(0, 1, 1, 0);
        n_vec++;
        if (overflow !== 1'b0 || match_count !== 16'd0) begin
            n_err++;
            $display("FAIL ovf_clear: got %0b/%0d want 0/0",
                     overflow, match_count);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            step(c < 8, 1, 0, 0);
        end
        step(1, 1, 0, 1);
        n_vec++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0 ||
            match_count !== 16'd9) begin
            n_err++;
            $display("FAIL full_pp: got %0d/%0b/%0d want 8/0/9",
                     fifo_level, overflow, match_count);
        end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (rd_data !== ((k < 7) ? 16'(k + 1) : 16'd30)) begin
                n_err++;
                $display("FAIL full_drain%0d: got %0d want %0d",
                         k, rd_data, (k < 7) ? k + 1 : 30);
            end
            step(0, 1, 0, 1);
        end
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_empty: got %0b want 0", rd_valid);
        end
    endtask

    task automatic test_clear_enable();
        do_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        n_vec++;
        if (fifo_level !== 4'd0 || match_count !== 16'd0 ||
            overflow !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clear: got %0d/%0d/%0b/%0b want 0/0/0/0",
                     fifo_level, match_count, overflow, rd_valid);
        end
        step(1, 1, 0, 0);
        n_vec++;
        if (rd_data !== 16'd4 || fifo_level !== 4'd1) begin
            n_err++;
            $display("FAIL clear_ts: got %0d/%0d want 4/1",
                     rd_data, fifo_level);
        end
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
        end
        n_vec++;
        if (fifo_level !== 4'd1 || match_count !== 16'd1 ||
            rd_data !== 16'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL enable_off: got %0d/%0d/%0d/%0b want 1/1/4/0",
                     fifo_level, match_count, rd_data, overflow);
        end
    endtask

    task automatic test_saturation();
        s_rst = 1'b1;
        step(0, 1, 0, 0);
        s_rst   = 1'b0;
        s_match = 1'b1;
        s_rdy   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0);
            n_vec++;
            if (s_valid !== 1'b1 || s_data !== 4'(i) || s_level !== 4'd1) begin
                n_err++;
                $display("FAIL sat_entry%0d: got %0b/%0d/%0d want 1/%0d/1",
                         i, s_valid, s_data, s_level, i % 16);
            end
            if (i == 17) begin
                n_vec++;
                if (s_data !== 4'd1) begin
                    n_err++;
                    $display("FAIL sat_wrap17: got %0d want 1", s_data);
                end
            end
        end
        s_match = 1'b0;
        s_rdy   = 1'b0;
        n_vec++;
        if (s_count !== 4'd15 || s_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sat_count: got %0d/%0b want 15/0",
                     s_count, s_ovf);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0, 0);
        end
        n_vec++;
        if (fifo_level !== 4'd5) begin
            n_err++;
            $display("FAIL mid_fill: got %0d want 5", fifo_level);
        end
        rst = 1'b1;
        step(1, 1, 0, 0);
        rst = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0 || rd_data !== 16'd0 || fifo_level !== 4'd0 ||
            match_count !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got %0b/%0d/%0d/%0d/%0b want all 0",
                     rd_valid, rd_data, fifo_level, match_count, overflow);
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== 16'd2 || fifo_level !== 4'd1) begin
            n_err++;
            $display("FAIL mid_after: got %0b/%0d/%0d want 1/2/1",
                     rd_valid, rd_data, fifo_level);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rdy_pct = ((n / 300) % 2 == 0) ? 30 : 85;
            rst = ($urandom_range(0, 499) == 0);
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < rdy_pct));
            rst = 1'b0;
            n_vec++;
            if (rd_valid !== (q.size() != 0)) begin
                n_err++;
                $display("FAIL rnd_valid@%0d: got %0b want %0b",
                         n, rd_valid, q.size() != 0);
            end
            n_vec++;
            if (fifo_level !== 4'(q.size())) begin
                n_err++;
                $display("FAIL rnd_level@%0d: got %0d want %0d",
                         n, fifo_level, q.size());
            end
            n_vec++;
            if (match_count !== 16'(mcnt) || overflow !== movf) begin
                n_err++;
                $display("FAIL rnd_cnt_ovf@%0d: got %0d/%0b want %0d/%0b",
                         n, match_count, overflow, mcnt, movf);
            end
            if (q.size() != 0) begin
                n_vec++;
                if (rd_data !== q[0]) begin
                    n_err++;
                    $display("FAIL rnd_data@%0d: got %0d want %0d",
                             n, rd_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        match    = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        rd_ready = 1'b0;
        s_rst    = 1'b1;
        s_match  = 1'b0;
        s_enable = 1'b1;
        s_clear  = 1'b0;
        s_rdy    = 1'b0;
        mcnt     = 0;
        movf     = 0;
        mts      = 16'd0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_clear_enable();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the overlapping "1011" sequence detector's one-cycle `match` pulse. Each accepted pulse is stamped with a free-running cycle timestamp and stored in a small first-word-fall-through FIFO. A host or test harness drains the FIFO over a valid/ready read port. The block also keeps a saturating total-match counter and a sticky overflow flag.

## Interface
Parameters:
- `TS_W`, 16: timestamp width, and the width of `rd_data`.
- `CNT_W`, 16: width of `match_count`.
- `DEPTH`, 8: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `match`  in  1  detection pulse from the sequence detector, sampled every cycle.
- `enable`  in  1  capture enable. When 0, `match` is ignored entirely.
- `clear`  in  1  synchronous soft clear of FIFO, counter and flag. Does not affect the timestamp.
- `rd_ready`  in  1  consumer ready.
- `rd_valid`  out  1  FIFO non-empty; `rd_data` is valid.
- `rd_data`  out  TS_W  head-entry timestamp.
- `fifo_level`  out  $clog2(DEPTH)+1  number of stored entries, 0 to DEPTH.
- `match_count`  out  CNT_W  accepted-or-dropped match total, saturating.
- `overflow`  out  1  sticky; set when a match is dropped because the FIFO is full.

## Operation
- **Timestamp `ts`:** internal TS_W-bit counter.
  - Held at 0 while `rst` is asserted.
  - Increments by 1 every edge where `rst` is 0.
  - Wraps from all-ones to 0 with no flag.
  - `clear` does not touch it.
  - Cycle n after reset release has ts = n mod 2^TS_W.
- **Push:** `hit` = `match & enable & ~clear`.
  - A push occurs on a hit when (fifo_level < DEPTH) or a pop occurs in the same cycle.
  - The stored value is `ts` of the cycle in which `match` was high.
- **Drop:** a hit with fifo_level == DEPTH and no same-cycle pop.
  - The entry is discarded and `overflow` is set to 1.
- **Pop:** `rd_valid & rd_ready & ~clear`. Removes the head entry.
- **Simultaneous push and pop:**
  - Level is unchanged.
  - When full, the new entry is written into the slot freed by the pop. Order is preserved and nothing is dropped.
- **`match_count`:** increments on every hit, pushed or dropped. It saturates at 2^CNT_W−1 and never wraps.
- **`clear`:** has priority over `match` and `rd_ready` in the same cycle.
  - Next cycle: fifo_level = 0, rd_valid = 0, match_count = 0, overflow = 0.
  - A match or pop presented in the clear cycle has no effect.
- **`rst`:** has priority over everything. Mid-operation reset discards FIFO contents and zeroes `ts`.
- **Storage:** DEPTH×TS_W register array with wrapping read/write pointers. `rd_data` is driven directly from the head entry.
- **`rd_data` when empty:** don't-care, but it must not be X after reset. Drive it from the array; the array is reset to 0.

## Timing
- Reset values:
  - rd_valid = 0, rd_data = 0, fifo_level = 0, match_count = 0, overflow = 0, ts = 0.
- Capture latency is 1 cycle. When a match in cycle n pushes into an empty FIFO, then in cycle n+1:
  - rd_valid = 1
  - rd_data = n
  - fifo_level = 1
- `match_count` and `overflow` update on the same edge as the push or drop.
- Pop:
  - The head advances on the edge where rd_valid & rd_ready.
  - The next entry appears on `rd_data` in the following cycle. Throughput is 1 entry per cycle.
- `rd_valid` never depends combinationally on `rd_ready`. All outputs are registered.
- Back-to-back matches every cycle are accepted at full rate until the FIFO is full.

## Test plan
- **Reset and basic capture:** reset, then matches in cycles 5, 6 and 9, with `enable`=1 and `rd_ready`=0.
  - After cycle 9: fifo_level = 3, match_count = 3, rd_data = 5.
  - Then raise `rd_ready`: `rd_data` reads 5, 6, 9 on consecutive cycles, then rd_valid = 0 and fifo_level = 0.
- **Overflow (DEPTH=8):** matches in cycles 10–19, no reads.
  - fifo_level = 8, overflow = 1, match_count = 10.
  - Draining yields 10 through 17.
  - overflow stays 1 until `clear`.
- **Full plus simultaneous pop/push:** fill to 8, then match in cycle 30 with `rd_ready`=1.
  - fifo_level stays 8 and overflow stays 0.
  - The last drained entry is 30.
- **Clear and enable:**
  - `clear` together with `match` in the same cycle: next cycle fifo_level = 0, match_count = 0, overflow = 0, and `ts` keeps counting.
  - `match` with `enable`=0: no change to any output.
- **Saturation and wrap (TS_W=4, CNT_W=4):** 20 consecutive matches from cycle 0 with continuous draining.
  - match_count ends at 15.
  - The entry for cycle 17 reads 1.
- **Reset mid-operation:** assert `rst` with 5 entries stored.
  - All outputs return to 0 next cycle.
  - After release, a match in cycle 2 reads back 2.
